// File: rtl/ibex_pkg.sv
// Shared types for the Ibex multiply/divide unit: operator encoding and the
// state encoding of the iterative multiplier/divider.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10,
        MD_DONE = 2'b11
    } md_iter_fsm_e;

endpackage

// File: rtl/ibex_iter_multdiv.sv
// Iterative radix-2 multiplier/divider: shift-add multiply and restoring divide
// on operand magnitudes, with the sign applied in a final fix-up cycle.
module ibex_iter_multdiv
    import ibex_pkg::*;
#(
    parameter int Width           = 32,
    parameter bit EarlyOutDivZero = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  md_op_e             operator_i,
    input  logic [1:0]         signed_mode_i,
    input  logic [Width-1:0]   op_a_i,
    input  logic [Width-1:0]   op_b_i,
    input  logic               data_ind_timing_i,
    input  logic               kill_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [Width-1:0]   result_o
);

    localparam int CntW = $clog2(Width);

    md_iter_fsm_e           state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2*Width-1:0]     acc_q, acc_d;
    logic [Width-1:0]       opb_q, opb_d;
    logic [Width-1:0]       opa_q, opa_d;
    md_op_e                 op_q, op_d;
    logic                   neg_a_q, neg_a_d;
    logic                   neg_b_q, neg_b_d;
    logic [Width-1:0]       result_q, result_d;
    logic                   out_valid_q, out_valid_d;

    logic                   accept, kill_active, start;
    logic                   sign_a, sign_b, in_is_mul, in_is_div, early_out;
    logic [Width-1:0]       mag_a, mag_b;
    logic                   op_is_mul_q;
    logic [Width:0]         mul_sum;
    logic [2*Width-1:0]     mul_next;
    logic [Width:0]         div_shift;
    logic                   div_ge;
    logic [Width-1:0]       div_rem;
    logic [2*Width-1:0]     div_next;
    logic [2*Width-1:0]     mul_res;
    logic                   div_zero;
    logic [Width-1:0]       fix_result;

    assign in_ready_o  = (state_q == MD_IDLE) | ((state_q == MD_DONE) & out_ready_i);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;

    assign accept      = in_valid_i & in_ready_o;
    assign kill_active = kill_i & (state_q != MD_IDLE);
    assign start       = accept & ~kill_active;

    assign sign_a    = signed_mode_i[0] & op_a_i[Width-1];
    assign sign_b    = signed_mode_i[1] & op_b_i[Width-1];
    assign mag_a     = sign_a ? -op_a_i : op_a_i;
    assign mag_b     = sign_b ? -op_b_i : op_b_i;
    assign in_is_mul = (operator_i == MD_OP_MULL) | (operator_i == MD_OP_MULH);
    assign in_is_div = ~in_is_mul;
    assign early_out = EarlyOutDivZero & ~data_ind_timing_i & in_is_div & (op_b_i == '0);

    assign op_is_mul_q = (op_q == MD_OP_MULL) | (op_q == MD_OP_MULH);

    // Multiply: high half accumulates, low half holds the multiplier and shifts out LSB-first.
    assign mul_sum  = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[Width-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    assign div_shift = acc_q[2*Width-1:Width-1];
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_rem   = div_ge ? Width'(div_shift - {1'b0, opb_q}) : div_shift[Width-1:0];
    assign div_next  = {div_rem, acc_q[Width-2:0], div_ge};

    assign mul_res  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign div_zero = (opb_q == '0);

    always_comb begin
        fix_result = '0;
        case (op_q)
            MD_OP_MULL: fix_result = mul_res[Width-1:0];
            MD_OP_MULH: fix_result = mul_res[2*Width-1:Width];
            MD_OP_DIV:  fix_result = div_zero ? '1 :
                                     ((neg_a_q ^ neg_b_q) ? -acc_q[Width-1:0] : acc_q[Width-1:0]);
            MD_OP_REM:  fix_result = div_zero ? opa_q :
                                     (neg_a_q ? -acc_q[2*Width-1:Width] : acc_q[2*Width-1:Width]);
            default:    fix_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        opa_d    = opa_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;

        case (state_q)
            MD_CALC: begin
                acc_d = op_is_mul_q ? mul_next : div_next;
                if (cnt_q == '0) begin
                    state_d = MD_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            MD_FIX: begin
                result_d = fix_result;
                state_d  = MD_DONE;
            end
            MD_DONE: begin
                if (out_ready_i) begin
                    state_d = MD_IDLE;
                end
            end
            default: ;
        endcase

        // A new request overrides the drain of the previous one (back-to-back).
        if (start) begin
            op_d    = operator_i;
            opa_d   = op_a_i;
            neg_a_d = sign_a;
            neg_b_d = sign_b;
            cnt_d   = CntW'(Width - 1);
            if (in_is_mul) begin
                acc_d = {{Width{1'b0}}, mag_b};
                opb_d = mag_a;
            end else begin
                acc_d = {{Width{1'b0}}, mag_a};
                opb_d = mag_b;
            end
            if (early_out) begin
                state_d  = MD_DONE;
                result_d = (operator_i == MD_OP_DIV) ? '1 : op_a_i;
            end else begin
                state_d = MD_CALC;
            end
        end

        if (kill_active) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end

        out_valid_d = (state_d == MD_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            opa_q       <= '0;
            op_q        <= MD_OP_MULL;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            opa_q       <= opa_d;
            op_q        <= op_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_ibex_iter_multdiv.sv
// Directed bench for ibex_iter_multdiv at Width=32: a vector table for results and
// latencies, plus sequences for kill, reset, output back-pressure and back-to-back.
module tb_ibex_iter_multdiv;
    import ibex_pkg::*;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    md_op_e        operator_i = MD_OP_MULL;
    logic [1:0]    signed_mode_i = 2'b00;
    logic [W-1:0]  op_a_i = '0;
    logic [W-1:0]  op_b_i = '0;
    logic          data_ind_timing_i = 1'b0;
    logic          kill_i = 1'b0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [W-1:0]  result_o;

    int n_checks = 0;
    int n_fails  = 0;

    ibex_iter_multdiv #(.Width(W), .EarlyOutDivZero(1'b1)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .operator_i        (operator_i),
        .signed_mode_i     (signed_mode_i),
        .op_a_i            (op_a_i),
        .op_b_i            (op_b_i),
        .data_ind_timing_i (data_ind_timing_i),
        .kill_i            (kill_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .result_o          (result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        md_op_e       op;
        logic [1:0]   sm;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         dit;
        logic [W-1:0] exp_res;
        int           exp_lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request, scrambles the inputs after the accept edge, and returns
    // the result together with the number of cycles until out_valid_o.
    task automatic run_op(input md_op_e op, input logic [1:0] sm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic dit, input logic kill_at_accept,
                          output logic [W-1:0] res, output int lat);
        int guard = 0;
        @(negedge clk_i);
        while (!in_ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        operator_i        = op;
        signed_mode_i     = sm;
        op_a_i            = a;
        op_b_i            = b;
        data_ind_timing_i = dit;
        kill_i            = kill_at_accept;
        in_valid_i        = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i        = 1'b0;
        kill_i            = 1'b0;
        op_a_i            = $urandom;
        op_b_i            = $urandom;
        signed_mode_i     = ~sm;
        data_ind_timing_i = ~dit;
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic expect_no_valid(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk_i);
            #1;
            if (out_valid_o) seen++;
        end
        check_output(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] held;
        int           lat;

        vecs[0]  = '{MD_OP_MULL, 2'b00, 32'd7,        32'd6,        1'b0, 32'h0000002A, 34};
        vecs[1]  = '{MD_OP_MULH, 2'b11, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 34};
        vecs[2]  = '{MD_OP_MULH, 2'b01, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'hFFFFFFFF, 34};
        vecs[3]  = '{MD_OP_DIV,  2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 34};
        vecs[4]  = '{MD_OP_REM,  2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 34};
        vecs[5]  = '{MD_OP_DIV,  2'b00, 32'd5,        32'd0,        1'b0, 32'hFFFFFFFF, 1};
        vecs[6]  = '{MD_OP_DIV,  2'b00, 32'd5,        32'd0,        1'b1, 32'hFFFFFFFF, 34};
        vecs[7]  = '{MD_OP_REM,  2'b00, 32'd5,        32'd0,        1'b0, 32'h00000005, 1};
        vecs[8]  = '{MD_OP_REM,  2'b00, 32'd5,        32'd0,        1'b1, 32'h00000005, 34};
        vecs[9]  = '{MD_OP_DIV,  2'b00, 32'd100,      32'd7,        1'b0, 32'h0000000E, 34};
        vecs[10] = '{MD_OP_REM,  2'b00, 32'd100,      32'd7,        1'b0, 32'h00000002, 34};
        vecs[11] = '{MD_OP_DIV,  2'b11, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFD, 34};
        vecs[12] = '{MD_OP_REM,  2'b11, 32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 34};
        vecs[13] = '{MD_OP_MULL, 2'b11, 32'hFFFFFFFD, 32'd5,        1'b0, 32'hFFFFFFF1, 34};
        vecs[14] = '{MD_OP_MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 34};
        vecs[15] = '{MD_OP_DIV,  2'b11, 32'hFFFFFFFB, 32'd0,        1'b1, 32'hFFFFFFFF, 34};
        vecs[16] = '{MD_OP_REM,  2'b11, 32'hFFFFFFFB, 32'd0,        1'b0, 32'hFFFFFFFB, 1};
        vecs[17] = '{MD_OP_MULL, 2'b00, 32'h12345678, 32'h00000010, 1'b0, 32'h23456780, 34};
        vecs[18] = '{MD_OP_MULH, 2'b10, 32'h00000002, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 34};
        vecs[19] = '{MD_OP_DIV,  2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 34};

        // Reset state
        #1;
        check_output("reset out_valid", 64'(out_valid_o), 64'd0);
        check_output("reset result",    64'(result_o),    64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_output("reset in_ready", 64'(in_ready_o), 64'd1);

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].dit, 1'b0, res, lat);
            check_output($sformatf("vec%0d result", i),  64'(res), 64'(vecs[i].exp_res));
            check_output($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
        end

        // Kill on the 10th CALC cycle
        @(negedge clk_i);
        operator_i = MD_OP_MULL; signed_mode_i = 2'b00; op_a_i = 32'd9; op_b_i = 32'd9;
        data_ind_timing_i = 1'b0; in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        kill_i = 1'b0;
        check_output("kill idle in_ready", 64'(in_ready_o), 64'd1);
        check_output("kill out_valid",     64'(out_valid_o), 64'd0);
        expect_no_valid("kill no late valid", 40);

        // Kill while idle must not block a same-cycle accept
        run_op(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 1'b0, 1'b1, res, lat);
        check_output("idle kill result",  64'(res), 64'd12);
        check_output("idle kill latency", 64'(lat), 64'd34);

        // Reset in the middle of CALC
        @(negedge clk_i);
        operator_i = MD_OP_MULL; signed_mode_i = 2'b00; op_a_i = 32'd7; op_b_i = 32'd6;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_output("midreset out_valid", 64'(out_valid_o), 64'd0);
        check_output("midreset result",    64'(result_o),    64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_output("midreset in_ready", 64'(in_ready_o), 64'd1);
        expect_no_valid("midreset no late valid", 40);

        // Back-pressure in DONE, then a back-to-back accept on the drain cycle
        out_ready_i = 1'b0;
        run_op(MD_OP_MULL, 2'b00, 32'd7, 32'd6, 1'b0, 1'b0, res, lat);
        check_output("bp result",  64'(res), 64'h2A);
        check_output("bp latency", 64'(lat), 64'd34);
        held = result_o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check_output($sformatf("bp hold%0d result", i), 64'(result_o), 64'(held));
            check_output($sformatf("bp hold%0d valid", i),  64'(out_valid_o), 64'd1);
        end
        @(negedge clk_i);
        check_output("bp in_ready low", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1;
        operator_i = MD_OP_DIV; signed_mode_i = 2'b00; op_a_i = 32'd100; op_b_i = 32'd7;
        data_ind_timing_i = 1'b0; in_valid_i = 1'b1;
        #1;
        check_output("b2b in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        op_a_i = 32'd1; op_b_i = 32'd1;
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check_output("b2b result",  64'(result_o), 64'h0000000E);
        check_output("b2b latency", 64'(lat),      64'd34);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ibex_iter_multdiv.md
IBEX_ITER_MULTDIV -- requirements
Module: ibex_iter_multdiv

Interface
REQ-001 SHALL have parameter Width, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have parameter EarlyOutDivZero, default 1'b1, enable 1-cycle divide-by-zero completion.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid_i, input, 1, request valid.
REQ-006 SHALL have port in_ready_o, output, 1, request accepted when in_valid_i & in_ready_o.
REQ-007 SHALL have port operator_i, input, ibex_pkg::md_op_e, MD_OP_MULL/MULH/DIV/REM.
REQ-008 SHALL have port signed_mode_i, input, 2, bit0 = op_a signed, bit1 = op_b signed.
REQ-009 SHALL have port op_a_i / op_b_i, input, Width each, operands.
REQ-010 SHALL have port data_ind_timing_i, input, 1, forces full latency on every operation.
REQ-011 SHALL have port kill_i, input, 1, abort the in-flight operation.
REQ-012 SHALL have port out_valid_o, output, 1, result valid.
REQ-013 SHALL have port out_ready_i, input, 1, result consumed when out_valid_o & out_ready_i.
REQ-014 SHALL have port result_o, output, Width, result.

Function
REQ-015 SHALL sample operator, signed mode, operands and data_ind_timing_i on the accept edge only; later input changes have no effect.
REQ-016 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-017 IDLE: in_ready_o=1; on accept -> CALC, iteration counter <- Width-1, operands converted to magnitude per signed_mode.
REQ-018 CALC: one radix-2 step per cycle (shift-add multiply over 2*Width accumulator; restoring divide); at counter==0 -> FIX, else counter decrements.
REQ-019 FIX: apply result sign (MUL: sign_a^sign_b; DIV quotient: sign_a^sign_b; REM: sign_a), select low half (MULL) or high half (MULH), register into result; -> DONE.
REQ-020 DONE: out_valid_o=1, result_o stable; on out_ready_i -> IDLE.
REQ-021 in_ready_o SHALL equal (state==IDLE) | (state==DONE & out_ready_i); accept in DONE goes directly to CALC (back-to-back).
REQ-022 Latency: out_valid_o SHALL first assert Width+2 cycles after the accept edge.
REQ-023 Divide by zero: quotient all-ones, remainder = op_a (unsigned and signed).
REQ-024 Signed overflow (op_a = most-negative, op_b = -1, DIV/REM): quotient = op_a, remainder = 0.
REQ-025 If EarlyOutDivZero=1, data_ind_timing_i=0 and DIV/REM with op_b==0: accept -> DONE directly, out_valid_o asserted 1 cycle after accept.
REQ-026 If data_ind_timing_i=1 latency SHALL be Width+2 for all operands, including REQ-023/REQ-024 cases.
REQ-027 kill_i in CALC/FIX/DONE SHALL force IDLE next edge, no out_valid_o for that operation; kill_i has priority over accept and over out_ready_i; kill_i in IDLE is ignored and does not block a same-cycle accept.
REQ-028 out_valid_o SHALL never assert in IDLE, CALC or FIX.
REQ-029 No combinational path from out_ready_i to out_valid_o or result_o.

Reset
REQ-030 rst_i SHALL asynchronously force state IDLE, counter 0, accumulators 0, result_o 0, out_valid_o 0; in_ready_o=1 once rst_i deasserted.
REQ-031 Reset mid-operation SHALL discard the operation with no out_valid_o afterwards.

Structure
REQ-032 FSM state enum (md_iter_fsm_e) SHALL be added to ibex_pkg; md_op_e reused from ibex_pkg.
REQ-033 SHALL be a single flat module, no sub-modules; counter width $clog2(Width).
REQ-034 Target size 150-300 RTL lines.

Verification (Width=32)
REQ-035 MULL 7*6, signed_mode 0 -> result 0x0000002A, out_valid_o 34 cycles after accept.
REQ-036 MULH signed_mode 2'b11, 0x80000000*0x80000000 -> 0x40000000; MULH signed_mode 2'b01, 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-037 DIV signed 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
REQ-038 DIVU 5/0, data_ind_timing_i=0 -> 0xFFFFFFFF after 1 cycle; data_ind_timing_i=1 -> same after 34 cycles; REMU 5/0 -> 0x00000005.
REQ-039 kill_i on 10th CALC cycle -> IDLE next edge, no out_valid_o; rst_i mid-CALC -> all outputs at reset values immediately.
REQ-040 out_ready_i low 5 cycles in DONE -> result_o stable; then back-to-back DIVU 100/7 accepted same cycle as drain -> 0x0000000E.
